// File: rtl/riscv_ifetch.sv
// Instruction-fetch stage: program RAM with a load port, a one-cycle synchronous fetch,
// and a valid/ready hand-off to decode that gates the PC enable.
module riscv_ifetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pcAddr,
  output logic              pcEn,
  input  logic              start,
  input  logic              halt,
  input  logic              ldEn,
  input  logic [ADDR_W-1:0] ldAddr,
  input  logic [DATA_W-1:0] ldData,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instrPc,
  output logic              instrValid,
  input  logic              idReady,
  output logic              busy,
  output logic [31:0]       fetchCount
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instrPc_q;
  logic [31:0]       cnt_q, cnt_d;
  logic              fetchLd;
  logic              handshake;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fetchLd   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !halt) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (halt) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_VALID;
          fetchLd = 1'b1;
        end
      end
      S_VALID: begin
        // halt wins over a pending handshake so the dropped word is never counted
        if (halt) begin
          state_d = S_IDLE;
        end else if (idReady) begin
          handshake = 1'b1;
          cnt_d     = cnt_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Program RAM keeps its contents across reset; loads are only accepted while idle.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && ldEn) begin
      mem[ldAddr] <= ldData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      instrPc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fetchLd) begin
        instr_q   <= mem[pcAddr];
        instrPc_q <= pcAddr;
      end
    end
  end

  assign pcEn       = handshake;
  assign instr      = instr_q;
  assign instrPc    = instrPc_q;
  assign instrValid = (state_q == S_VALID);
  assign busy       = (state_q != S_IDLE);
  assign fetchCount = cnt_q;

endmodule

// File: doc/riscv_ifetch.md
# riscv_ifetch

Instruction-fetch stage that sits between the program counter and decode. It holds the program in a word-addressed instruction RAM and reads the word at the PC's current address. It presents that word to decode with a valid/ready handshake, and it drives the PC's `pcEn` so the PC advances only when decode consumes an instruction. It also provides a program-load port, a start/halt control, and a fetched-instruction counter.

## Interface
- `ADDR_W`, 8: instruction address width in words; RAM depth is 2^ADDR_W. Matches the PC's 8-bit word-address output.
- `DATA_W`, 32: instruction width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pcAddr`  in  ADDR_W  current word address from the PC output.
- `pcEn`  out  1  PC enable; one-cycle pulse when an instruction is consumed.
- `start`  in  1  begin fetching from the current `pcAddr`; honoured only in IDLE.
- `halt`  in  1  stop fetching and return to IDLE.
- `ldEn`  in  1  program-load write strobe; honoured only in IDLE.
- `ldAddr`  in  ADDR_W  load word address.
- `ldData`  in  DATA_W  load word.
- `instr`  out  DATA_W  fetched instruction (registered).
- `instrPc`  out  ADDR_W  address `instr` was fetched from.
- `instrValid`  out  1  `instr`/`instrPc` valid for decode.
- `idReady`  in  1  decode accepts `instr` this cycle.
- `busy`  out  1  high in FETCH or VALID.
- `fetchCount`  out  32  number of instructions consumed since the last start or reset.

## Operation
- RAM: 2^ADDR_W x DATA_W, one synchronous write port (load) and one synchronous read port (fetch). It is not cleared by reset.
- States are IDLE, FETCH and VALID.
- IDLE:
  - `ldEn`=1 writes `ldData` to `mem[ldAddr]` at the edge.
  - `start`=1 with `halt`=0 goes to FETCH and clears `fetchCount`.
  - `start`=1 with `halt`=1 stays in IDLE.
- FETCH:
  - `pcEn`=0, `instrValid`=0.
  - At the edge, `instr` <= `mem[pcAddr]` and `instrPc` <= `pcAddr`, then go to VALID.
  - `halt`=1 returns to IDLE, leaving `instr`/`instrPc` unchanged.
- VALID:
  - `instrValid`=1.
  - `halt`=1 (priority over `idReady`): go to IDLE; `pcEn`=0; the instruction is dropped and not counted.
  - Otherwise, `idReady`=1 is a handshake: `pcEn`=1 combinationally this cycle, `fetchCount`+1, go to FETCH. The PC applies its own `pcSrc`/offset at the same edge.
  - Otherwise (`idReady`=0): hold `instr`/`instrPc`; `pcEn`=0.
- `ldEn` and `start` outside IDLE are ignored; no RAM write takes place.
- `pcEn` is asserted only in VALID on a handshake; it is never high in IDLE or FETCH.
- Address wrap (PC going 2^ADDR_W-1 to 0) is transparent: the fetch reads whatever address is presented.
- `fetchCount` wraps modulo 2^32.

## Timing
- Reset values (asserted asynchronously):
  - State IDLE.
  - `instr`=0, `instrPc`=0, `instrValid`=0.
  - `pcEn`=0, `busy`=0, `fetchCount`=0.
- Reset mid-operation returns to IDLE immediately with the values above; RAM contents are kept.
- `start` sampled at edge N: FETCH in cycle N+1, `instrValid`=1 from cycle N+2.
- Read latency is one cycle: `pcAddr` is stable during FETCH because `pcEn`=0.
- Throughput with `idReady` tied high is one instruction per 2 cycles; `pcEn` pulses every other cycle.
- `instrValid` falls at the edge that ends the handshake cycle. It rises again one cycle later with the word at the updated PC.
- Load write is visible to a fetch in any later cycle; no bypass is needed because load and fetch are mutually exclusive.

## Test plan
- Reset: with `rst_n`=0 asynchronously mid-cycle, all outputs are 0 immediately, and stay 0 with `start`=0 for 10 cycles.
- Load and run: load `mem[0..3]`=`32'h00500093`, `32'h00A00113`, `32'h002081B3`, `32'h00000013`. Bench PC model starts at 0 and increments by 1 on `pcEn`. Pulse `start` with `idReady`=1. Required: `instr` delivers the four words in order with `instrPc`=0,1,2,3; `pcEn` pulses every second cycle; `fetchCount`=4.
- Backpressure: hold `idReady`=0 for 5 cycles in VALID. `instr`/`instrPc` stay stable, `pcEn`=0 throughout, and exactly one handshake occurs when `idReady` rises.
- Halt priority: drive `halt`=1 and `idReady`=1 together in VALID. Required: no `pcEn`, state IDLE, `fetchCount` unchanged, `busy`=0 the next cycle.
- Ignored controls: `ldEn` to address 2 with `32'hDEADBEEF` while running leaves `mem[2]` unchanged, shown by a later fetch. `start` while busy has no effect and does not clear `fetchCount`.
- Reset mid-run and wrap: reset in VALID, then restart with the PC model at 255. The fetch returns the original `mem[255]`, and after a handshake the next fetch returns `mem[0]` with `instrPc`=0.
